// File: rtl/etapa_busqueda_if.sv
// ============================================================================
// Module      : etapa_busqueda_if
// Description : Instruction-memory, redirect and decode handshake bundle for
//               the fetch stage. The master side is the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface etapa_busqueda_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_op;
    logic [31:0] if_pc4;
    logic        align_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        input  id_ready,
        output if_valid,
        output if_instr,
        output if_op,
        output if_pc4,
        output align_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        output id_ready,
        input  if_valid,
        input  if_instr,
        input  if_op,
        input  if_pc4,
        input  align_err
    );
endinterface

`default_nettype wire

// File: rtl/etapa_busqueda.sv
// ============================================================================
// Module      : etapa_busqueda
// Description : Instruction-fetch stage: owns the PC, fetches words over a
//               req/ack handshake into a 2-entry queue, serves decode under
//               valid/ready and handles branch/jump redirects.
//               Optional macro ETAPA_BUSQUEDA_ALIGN_CHECK_EN enables redirect
//               alignment checking and forces word-aligned redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module etapa_busqueda #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    etapa_busqueda_if.master      bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [31:0]       pc_q,        pc_d;
    logic [31:0]       req_addr_q,  req_addr_d;
    logic [1:0]        count_q,     count_d;
    logic              head_q,      head_d;
    logic [1:0][31:0]  instr_q,     instr_d;
    logic [1:0][31:0]  pc4_q,       pc4_d;
    logic              align_err_q, align_err_d;

    logic        in_flight;
    logic        pop;
    logic        push;
    logic [1:0]  occ_next;
    logic        room;
    logic        wr_idx;
    logic [31:0] tgt;
    logic        misalign;

`ifdef ETAPA_BUSQUEDA_ALIGN_CHECK_EN
    assign tgt      = {bus.redirect_pc[31:2], 2'b00};
    assign misalign = bus.redirect & (|bus.redirect_pc[1:0]);
`else
    assign tgt      = bus.redirect_pc;
    assign misalign = 1'b0;
`endif

    assign in_flight = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign pop       = (count_q != 2'd0) & bus.id_ready & ~bus.redirect;
    assign push      = bus.imem_ack & (state_q == ST_REQ) & ~bus.redirect;
    assign occ_next  = count_q + {1'b0, push} - {1'b0, pop};
    // A request is only issued if its data is guaranteed a free slot.
    assign room      = (occ_next < 2'd2);
    assign wr_idx    = head_q ^ count_q[0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        count_d     = count_q;
        head_d      = head_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        align_err_d = misalign;

        if (bus.redirect) begin
            count_d = 2'd0;
            if (in_flight && !bus.imem_ack) begin
                // The outstanding request cannot be cancelled; wait out its ack.
                state_d = ST_DRAIN;
                pc_d    = tgt;
            end else begin
                state_d    = ST_REQ;
                req_addr_d = tgt;
                pc_d       = tgt + 32'd4;
            end
        end else begin
            count_d = occ_next;
            if (pop) begin
                head_d = ~head_q;
            end
            if (push) begin
                instr_d[wr_idx] = bus.imem_rdata;
                pc4_d[wr_idx]   = req_addr_q + 32'd4;
            end

            case (state_q)
                ST_IDLE: begin
                    if (room) begin
                        state_d    = ST_REQ;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        if (room) begin
                            state_d    = ST_REQ;
                            req_addr_d = pc_q;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.imem_ack) begin
                        state_d    = ST_REQ;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RESET;
            req_addr_q  <= PC_RESET;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            instr_q     <= '0;
            pc4_q       <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            align_err_q <= align_err_d;
        end
    end

    assign bus.imem_req  = in_flight;
    assign bus.imem_addr = req_addr_q;
    assign bus.if_valid  = (count_q != 2'd0);
    assign bus.if_instr  = instr_q[head_q];
    assign bus.if_op     = instr_q[head_q][31:26];
    assign bus.if_pc4    = pc4_q[head_q];
    assign bus.align_err = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_etapa_busqueda.sv
// ============================================================================
// Module      : tb_etapa_busqueda
// Description : Randomized bench for etapa_busqueda against a queue-based
//               transaction model of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_etapa_busqueda;

    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    etapa_busqueda_if bus ();

    etapa_busqueda #(.PC_RESET(PC_RST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: instruction queue plus one outstanding request.
    logic [63:0] mq[$];
    bit          m_pend;
    bit          m_stale;
    logic [31:0] m_paddr;
    logic [31:0] m_pc;
    bit          m_align;
    int          ack_n;

    task automatic model_reset();
        mq.delete();
        m_pend  = 0;
        m_stale = 0;
        m_paddr = PC_RST;
        m_pc    = PC_RST;
        m_align = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (bus.redirect) begin
            t = bus.redirect_pc;
`ifdef ETAPA_BUSQUEDA_ALIGN_CHECK_EN
            m_align = (t[1:0] != 2'b00);
            t[1:0]  = 2'b00;
`else
            m_align = 0;
`endif
            mq.delete();
            if (m_pend && !bus.imem_ack) begin
                m_stale = 1;
                m_pc    = t;
            end else begin
                m_pend  = 1;
                m_stale = 0;
                m_paddr = t;
                m_pc    = t + 32'd4;
            end
        end else begin
            m_align = 0;
            if (mq.size() > 0 && bus.id_ready) void'(mq.pop_front());
            if (m_pend && bus.imem_ack) begin
                if (!m_stale) mq.push_back({bus.imem_rdata, m_paddr + 32'd4});
                m_pend  = 0;
                m_stale = 0;
            end
            if (!m_pend && mq.size() < 2) begin
                m_pend  = 1;
                m_paddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] h;
        chk("imem_req",  {31'd0, bus.imem_req},  {31'd0, m_pend});
        chk("imem_addr", bus.imem_addr, m_paddr);
        chk("if_valid",  {31'd0, bus.if_valid},  {31'd0, (mq.size() > 0)});
        chk("align_err", {31'd0, bus.align_err}, {31'd0, m_align});
        if (mq.size() > 0) begin
            h = mq[0];
            chk("if_instr", bus.if_instr, h[63:32]);
            chk("if_pc4",   bus.if_pc4,   h[31:0]);
            chk("if_op",    {26'd0, bus.if_op}, {26'd0, h[63:58]});
        end
    endtask

    task automatic drive(input int i);
        bit ack;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        if (i < 20) begin
            ack = m_pend;  bus.id_ready = 1'b1;
        end else if (i < 35) begin
            ack = m_pend;  bus.id_ready = 1'b0;
        end else if (i < 50) begin
            ack = m_pend;  bus.id_ready = 1'b1;
        end else if (i == 50) begin
            ack = 0; bus.id_ready = 1'b1;
            bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
        end else if (i < 53) begin
            ack = 0; bus.id_ready = 1'b1;
        end else if (i == 60) begin
            ack = m_pend; bus.id_ready = 1'b1;
            bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
        end else if (i == 70) begin
            ack = 0; bus.id_ready = 1'b1;
            bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
        end else if (i < 80) begin
            ack = m_pend; bus.id_ready = 1'b1;
        end else begin
            ack = m_pend && ($urandom_range(0, 2) != 0);
            bus.id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = $urandom;
                if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
            end
        end
        bus.imem_ack = ack;
        if (ack) begin
            if (ack_n == 0)      bus.imem_rdata = 32'h0400_0000;
            else if (ack_n == 1) bus.imem_rdata = 32'h0000_0000;
            else                 bus.imem_rdata = $urandom;
            ack_n++;
        end else begin
            bus.imem_rdata = $urandom;
        end
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready    = 1'b1;
        ack_n = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_imem_req",  {31'd0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, PC_RST);
        chk("rst_if_valid",  {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_instr",  bus.if_instr, 32'd0);
        chk("rst_if_pc4",    bus.if_pc4, 32'd0);
        chk("rst_align_err", {31'd0, bus.align_err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            drive(i);
        end

        // Asynchronous reset while a request is outstanding.
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("mid_rst_addr",     bus.imem_addr, PC_RST);
        @(negedge clk);
        rst_n = 1'b1;
        ack_n = 2;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
            drive(100 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
